// File: rtl/uart_fifo_pkg.sv
// Shared types and helpers for the UART TX/RX buffering stage.
package uart_fifo_pkg;

    // Character width the stored RX entry layout is described for.
    localparam int UART_DATA_W = 8;

    // One stored RX character with its line status, MSB first.
    typedef struct packed {
        logic                   bi;
        logic                   fe;
        logic                   pe;
        logic [UART_DATA_W-1:0] data;
    } rx_entry_t;

    // RX trigger select encoding.
    typedef enum logic [1:0] {
        TRIG_ONE     = 2'b00,
        TRIG_QUARTER = 2'b01,
        TRIG_HALF    = 2'b10,
        TRIG_NEAR    = 2'b11
    } rxfiftl_e;

    // Number of stored RX characters that raises the trigger in FIFO mode.
    function automatic int trig_level(input rxfiftl_e sel, input int depth);
        case (sel)
            TRIG_ONE:     return 1;
            TRIG_QUARTER: return depth / 4;
            TRIG_HALF:    return depth / 2;
            default:      return depth - 2;
        endcase
    endfunction

    // True when any of the {bi, fe, pe} status bits is set.
    function automatic logic has_err(input logic [2:0] status);
        return |status;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush and a depth-1 mode.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             depth1,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             push_ok,
    output logic             pop_ok
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    eff_depth;
    logic [CW-1:0]    cnt_n;

    // A pop frees the slot a same-cycle push needs, so a full FIFO can do both.
    assign eff_depth = depth1 ? CW'(1) : CW'(DEPTH);
    assign pop_ok    = pop & ~empty & ~clr;
    assign push_ok   = push & (~full | pop_ok) & ~clr;
    assign rdata     = mem[rd_ptr];

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        cnt_n = count;
        if (clr)
            cnt_n = '0;
        else if (push_ok && !pop_ok)
            cnt_n = count + CW'(1);
        else if (!push_ok && pop_ok)
            cnt_n = count - CW'(1);
    end

    // Pointers and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (clr) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            end
            count <= cnt_n;
            full  <= (cnt_n == eff_depth);
            empty <= (cnt_n == '0);
        end
    end

    // Storage; a flush leaves old contents in place so the head shows stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// UART TX/RX buffering: two FIFOs plus overrun, error tracking, trigger and timeout.
module uart_fifo_ctrl
    import uart_fifo_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_W     = 8,
    parameter int TOUT_CHARS = 4,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              fifoen,
    input  logic              txclr,
    input  logic              rxclr,
    input  logic [1:0]        rxfiftl,
    input  logic [DATA_W-1:0] wdata,
    input  logic              thr_wr_en,
    input  logic              tsr_load,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_full,
    output logic              tx_empty,
    output logic [CW-1:0]     tx_count,
    input  logic [DATA_W-1:0] rsr_data,
    input  logic              rx_pe,
    input  logic              rx_fe,
    input  logic              rx_bi,
    input  logic              rx_done,
    input  logic              rbr_rd_en,
    output logic [DATA_W-1:0] rbr,
    output logic              rbr_pe,
    output logic              rbr_fe,
    output logic              rbr_bi,
    output logic              rx_full,
    output logic              rx_empty,
    output logic [CW-1:0]     rx_count,
    output logic              rx_trig,
    output logic              rx_err_any,
    output logic              overrun,
    input  logic              lsr_rd,
    input  logic              char_tick,
    output logic              rx_timeout
);

    localparam int TW = $clog2(TOUT_CHARS + 1);

    logic              fifoen_q;
    logic              mode_chg;
    logic              tx_flush;
    logic              rx_flush;
    logic              tx_push_ok;
    logic              tx_pop_ok;
    logic              rx_push_ok;
    logic              rx_pop_ok;
    logic [DATA_W+2:0] rx_wentry;
    logic [DATA_W+2:0] rx_rentry;
    logic [CW-1:0]     trig_lvl;
    logic [CW-1:0]     ecnt;
    logic [CW-1:0]     ecnt_n;
    logic              err_in;
    logic              err_out;
    logic [TW-1:0]     tcnt;
    logic [TW-1:0]     tcnt_n;
    logic              tout_rst;

    // A mode change empties both sides exactly like an explicit clear.
    assign mode_chg = fifoen ^ fifoen_q;
    assign tx_flush = txclr | mode_chg;
    assign rx_flush = rxclr | mode_chg;

    // Track the mode to detect changes.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) fifoen_q <= 1'b0;
        else        fifoen_q <= fifoen;
    end

    uart_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_tx_fifo (
        .clk     (pclk),
        .rst     (preset),
        .clr     (tx_flush),
        .depth1  (~fifoen),
        .push    (thr_wr_en),
        .pop     (tsr_load),
        .wdata   (wdata),
        .rdata   (tx_data),
        .count   (tx_count),
        .full    (tx_full),
        .empty   (tx_empty),
        .push_ok (tx_push_ok),
        .pop_ok  (tx_pop_ok)
    );

    // Entry layout {bi, fe, pe, data}.
    assign rx_wentry = {rx_bi, rx_fe, rx_pe, rsr_data};

    uart_sync_fifo #(
        .WIDTH (DATA_W + 3),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_rx_fifo (
        .clk     (pclk),
        .rst     (preset),
        .clr     (rx_flush),
        .depth1  (~fifoen),
        .push    (rx_done),
        .pop     (rbr_rd_en),
        .wdata   (rx_wentry),
        .rdata   (rx_rentry),
        .count   (rx_count),
        .full    (rx_full),
        .empty   (rx_empty),
        .push_ok (rx_push_ok),
        .pop_ok  (rx_pop_ok)
    );

    assign rbr    = rx_rentry[DATA_W-1:0];
    assign rbr_pe = rx_rentry[DATA_W];
    assign rbr_fe = rx_rentry[DATA_W+1];
    assign rbr_bi = rx_rentry[DATA_W+2];

    // Trigger is the one combinational status output.
    assign trig_lvl = CW'(trig_level(rxfiftl_e'(rxfiftl), DEPTH));
    assign rx_trig  = fifoen ? (rx_count >= trig_lvl) : ~rx_empty;

    // Sticky overrun: a dropped RX character sets it, an LSR read clears it.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset)
            overrun <= 1'b0;
        else if (rx_done && rx_full && !rx_pop_ok && !rx_flush)
            overrun <= 1'b1;
        else if (lsr_rd)
            overrun <= 1'b0;
    end

    // Count of stored entries that carry any error bit.
    assign err_in  = rx_push_ok & has_err({rx_bi, rx_fe, rx_pe});
    assign err_out = rx_pop_ok  & has_err({rbr_bi, rbr_fe, rbr_pe});

    // Next error count; a same-cycle in and out cancel.
    always_comb begin
        ecnt_n = ecnt;
        if (rx_flush)
            ecnt_n = '0;
        else if (err_in && !err_out)
            ecnt_n = ecnt + CW'(1);
        else if (!err_in && err_out)
            ecnt_n = ecnt - CW'(1);
    end

    // Error count and its registered non-zero flag.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            ecnt       <= '0;
            rx_err_any <= 1'b0;
        end else begin
            ecnt       <= ecnt_n;
            rx_err_any <= (ecnt_n != '0);
        end
    end

    // Timeout runs as a down-counter of remaining idle character times;
    // reaching zero is the same as having counted TOUT_CHARS up.
    assign tout_rst = rx_done | rbr_rd_en | rx_flush | rx_empty;

    // Next remaining-idle-time value.
    always_comb begin
        tcnt_n = tcnt;
        if (tout_rst)
            tcnt_n = TW'(TOUT_CHARS);
        else if (char_tick && fifoen && tcnt != '0)
            tcnt_n = tcnt - TW'(1);
    end

    // Timeout counter and registered terminal-count flag.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            tcnt       <= TW'(TOUT_CHARS);
            rx_timeout <= 1'b0;
        end else begin
            tcnt       <= tcnt_n;
            rx_timeout <= fifoen && (tcnt_n == '0);
        end
    end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed self-checking bench for uart_fifo_ctrl (DEPTH=16, DATA_W=8, TOUT_CHARS=4).
module tb_uart_fifo_ctrl;

    logic       pclk = 1'b0;
    logic       preset;
    logic       fifoen;
    logic       txclr;
    logic       rxclr;
    logic [1:0] rxfiftl;
    logic [7:0] wdata;
    logic       thr_wr_en;
    logic       tsr_load;
    logic [7:0] tx_data;
    logic       tx_full;
    logic       tx_empty;
    logic [4:0] tx_count;
    logic [7:0] rsr_data;
    logic       rx_pe;
    logic       rx_fe;
    logic       rx_bi;
    logic       rx_done;
    logic       rbr_rd_en;
    logic [7:0] rbr;
    logic       rbr_pe;
    logic       rbr_fe;
    logic       rbr_bi;
    logic       rx_full;
    logic       rx_empty;
    logic [4:0] rx_count;
    logic       rx_trig;
    logic       rx_err_any;
    logic       overrun;
    logic       lsr_rd;
    logic       char_tick;
    logic       rx_timeout;

    int n_checks = 0;
    int n_errors = 0;

    uart_fifo_ctrl dut (
        .pclk       (pclk),
        .preset     (preset),
        .fifoen     (fifoen),
        .txclr      (txclr),
        .rxclr      (rxclr),
        .rxfiftl    (rxfiftl),
        .wdata      (wdata),
        .thr_wr_en  (thr_wr_en),
        .tsr_load   (tsr_load),
        .tx_data    (tx_data),
        .tx_full    (tx_full),
        .tx_empty   (tx_empty),
        .tx_count   (tx_count),
        .rsr_data   (rsr_data),
        .rx_pe      (rx_pe),
        .rx_fe      (rx_fe),
        .rx_bi      (rx_bi),
        .rx_done    (rx_done),
        .rbr_rd_en  (rbr_rd_en),
        .rbr        (rbr),
        .rbr_pe     (rbr_pe),
        .rbr_fe     (rbr_fe),
        .rbr_bi     (rbr_bi),
        .rx_full    (rx_full),
        .rx_empty   (rx_empty),
        .rx_count   (rx_count),
        .rx_trig    (rx_trig),
        .rx_err_any (rx_err_any),
        .overrun    (overrun),
        .lsr_rd     (lsr_rd),
        .char_tick  (char_tick),
        .rx_timeout (rx_timeout)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    task automatic tx_push(input logic [7:0] d);
        wdata = d; thr_wr_en = 1'b1;
        cyc();
        thr_wr_en = 1'b0;
    endtask

    task automatic tx_pop();
        tsr_load = 1'b1;
        cyc();
        tsr_load = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] d, input logic pe, input logic fe, input logic bi);
        rsr_data = d; rx_pe = pe; rx_fe = fe; rx_bi = bi; rx_done = 1'b1;
        cyc();
        rx_done = 1'b0; rx_pe = 1'b0; rx_fe = 1'b0; rx_bi = 1'b0;
    endtask

    task automatic rx_pop();
        rbr_rd_en = 1'b1;
        cyc();
        rbr_rd_en = 1'b0;
    endtask

    task automatic tick();
        char_tick = 1'b1;
        cyc();
        char_tick = 1'b0;
        cyc();
    endtask

    task automatic rx_clear();
        rxclr = 1'b1;
        cyc();
        rxclr = 1'b0;
    endtask

    initial begin
        preset = 1'b1; fifoen = 1'b1; txclr = 1'b0; rxclr = 1'b0; rxfiftl = 2'b00;
        wdata = '0; thr_wr_en = 1'b0; tsr_load = 1'b0; rsr_data = '0;
        rx_pe = 1'b0; rx_fe = 1'b0; rx_bi = 1'b0; rx_done = 1'b0; rbr_rd_en = 1'b0;
        lsr_rd = 1'b0; char_tick = 1'b0;
        cyc(); cyc();

        // Reset values
        check("rst_tx_count", 32'(tx_count), 0);
        check("rst_tx_empty", 32'(tx_empty), 1);
        check("rst_tx_full", 32'(tx_full), 0);
        check("rst_rx_empty", 32'(rx_empty), 1);
        check("rst_rx_full", 32'(rx_full), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_err_any", 32'(rx_err_any), 0);
        check("rst_timeout", 32'(rx_timeout), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_rbr", 32'(rbr), 0);
        preset = 1'b0;
        cyc(); cyc();

        // TX fill, overflow drop, ordered drain
        for (int i = 0; i < 16; i++) tx_push(8'(i));
        check("tx_fill_count", 32'(tx_count), 16);
        check("tx_fill_full", 32'(tx_full), 1);
        tx_push(8'hAA);
        check("tx_ovf_count", 32'(tx_count), 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("tx_order_%0d", i), 32'(tx_data), i);
            tx_pop();
        end
        check("tx_drain_empty", 32'(tx_empty), 1);
        check("tx_drain_count", 32'(tx_count), 0);
        check("tx_aa_dropped", 32'(tx_data), 0);
        tx_pop();
        check("tx_pop_empty_cnt", 32'(tx_count), 0);

        // RX fill, overrun, full pop+push, set-wins, clear keeps overrun
        for (int i = 0; i < 16; i++) rx_push(8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        check("rx_fill_full", 32'(rx_full), 1);
        check("rx_fill_count", 32'(rx_count), 16);
        check("rx_fill_ovr", 32'(overrun), 0);
        rx_push(8'h99, 1'b0, 1'b0, 1'b0);
        check("rx_ovr_set", 32'(overrun), 1);
        check("rx_ovr_count", 32'(rx_count), 16);
        lsr_rd = 1'b1; cyc(); lsr_rd = 1'b0;
        check("rx_ovr_clr", 32'(overrun), 0);
        rsr_data = 8'h55; rx_done = 1'b1; rbr_rd_en = 1'b1;
        cyc();
        rx_done = 1'b0; rbr_rd_en = 1'b0;
        check("rx_pp_count", 32'(rx_count), 16);
        check("rx_pp_no_ovr", 32'(overrun), 0);
        check("rx_pp_head", 32'(rbr), 32'h11);
        rx_done = 1'b1; lsr_rd = 1'b1;
        cyc();
        rx_done = 1'b0; lsr_rd = 1'b0;
        check("rx_ovr_set_wins", 32'(overrun), 1);
        rx_clear();
        check("rx_clr_empty", 32'(rx_empty), 1);
        check("rx_clr_keeps_ovr", 32'(overrun), 1);
        lsr_rd = 1'b1; cyc(); lsr_rd = 1'b0;
        check("rx_ovr_clr2", 32'(overrun), 0);

        // Trigger levels
        rxfiftl = 2'b01;
        for (int i = 0; i < 3; i++) rx_push(8'(i), 1'b0, 1'b0, 1'b0);
        check("trig_q_3", 32'(rx_trig), 0);
        rx_push(8'h03, 1'b0, 1'b0, 1'b0);
        check("trig_q_4", 32'(rx_trig), 1);
        rxfiftl = 2'b11; #1;
        check("trig_n_4", 32'(rx_trig), 0);
        for (int i = 4; i < 13; i++) rx_push(8'(i), 1'b0, 1'b0, 1'b0);
        check("trig_n_13", 32'(rx_trig), 0);
        rx_push(8'h0D, 1'b0, 1'b0, 1'b0);
        check("trig_n_14", 32'(rx_trig), 1);
        rxfiftl = 2'b00;

        // Holding-register mode
        fifoen = 1'b0; cyc();
        check("nf_flush_empty", 32'(rx_empty), 1);
        check("nf_trig_empty", 32'(rx_trig), 0);
        rx_push(8'h5A, 1'b0, 1'b0, 1'b0);
        check("nf_trig_one", 32'(rx_trig), 1);
        check("nf_full_one", 32'(rx_full), 1);
        rx_push(8'h5B, 1'b0, 1'b0, 1'b0);
        check("nf_ovr", 32'(overrun), 1);
        check("nf_head_kept", 32'(rbr), 32'h5A);
        lsr_rd = 1'b1; cyc(); lsr_rd = 1'b0;
        fifoen = 1'b1; cyc();
        check("nf_back_empty", 32'(rx_empty), 1);

        // Error tracking
        rx_push(8'h01, 1'b0, 1'b0, 1'b0);
        rx_push(8'h02, 1'b1, 1'b0, 1'b0);
        check("err_any_set", 32'(rx_err_any), 1);
        check("err_head_clean_pe", 32'(rbr_pe), 0);
        rx_pop();
        check("err_still_set", 32'(rx_err_any), 1);
        check("err_head_pe", 32'(rbr_pe), 1);
        check("err_head_data", 32'(rbr), 32'h02);
        rx_pop();
        check("err_cleared", 32'(rx_err_any), 0);
        rx_push(8'h03, 1'b0, 1'b1, 1'b0);
        check("err_head_fe", 32'(rbr_fe), 1);
        rsr_data = 8'h04; rx_bi = 1'b1; rx_done = 1'b1; rbr_rd_en = 1'b1;
        cyc();
        rx_bi = 1'b0; rx_done = 1'b0; rbr_rd_en = 1'b0;
        check("err_swap_any", 32'(rx_err_any), 1);
        check("err_head_bi", 32'(rbr_bi), 1);
        rx_pop();
        check("err_swap_clear", 32'(rx_err_any), 0);

        // Character timeout
        rx_push(8'h21, 1'b0, 1'b0, 1'b0);
        rx_push(8'h22, 1'b0, 1'b0, 1'b0);
        tick(); tick(); tick();
        check("tout_3", 32'(rx_timeout), 0);
        tick();
        check("tout_4", 32'(rx_timeout), 1);
        tick();
        check("tout_sat", 32'(rx_timeout), 1);
        rx_pop();
        check("tout_rd_clr", 32'(rx_timeout), 0);
        tick(); tick();
        rx_push(8'h23, 1'b0, 1'b0, 1'b0);
        tick(); tick(); tick();
        check("tout_restart", 32'(rx_timeout), 0);
        tick();
        check("tout_after_restart", 32'(rx_timeout), 1);
        rx_clear();
        check("tout_clr", 32'(rx_timeout), 0);

        // Mode switch flushes both sides
        tx_push(8'h31); tx_push(8'h32);
        rx_push(8'h41, 1'b0, 1'b0, 1'b0); rx_push(8'h42, 1'b0, 1'b0, 1'b0);
        fifoen = 1'b0; cyc();
        check("mode_tx_empty", 32'(tx_empty), 1);
        check("mode_rx_empty", 32'(rx_empty), 1);
        check("mode_rx_count", 32'(rx_count), 0);
        fifoen = 1'b1; cyc();

        // Clear beats a same-cycle push
        tx_push(8'h50);
        wdata = 8'h51; thr_wr_en = 1'b1; txclr = 1'b1;
        cyc();
        thr_wr_en = 1'b0; txclr = 1'b0;
        check("txclr_push_empty", 32'(tx_empty), 1);
        check("txclr_push_count", 32'(tx_count), 0);

        // Asynchronous reset mid-operation
        tx_push(8'h61); tx_push(8'h62);
        rx_push(8'h71, 1'b1, 1'b0, 1'b0);
        fifoen = 1'b0; cyc();
        rx_push(8'h72, 1'b0, 1'b0, 1'b0);
        rx_push(8'h73, 1'b0, 1'b0, 1'b0);
        check("pre_rst_ovr", 32'(overrun), 1);
        fifoen = 1'b1; cyc();
        tx_push(8'h63);
        rx_push(8'h74, 1'b0, 1'b1, 1'b0);
        #2 preset = 1'b1;
        #1;
        check("arst_tx_count", 32'(tx_count), 0);
        check("arst_tx_empty", 32'(tx_empty), 1);
        check("arst_rx_empty", 32'(rx_empty), 1);
        check("arst_overrun", 32'(overrun), 0);
        check("arst_err_any", 32'(rx_err_any), 0);
        check("arst_tx_data", 32'(tx_data), 0);
        check("arst_rbr", 32'(rbr), 0);
        cyc();
        preset = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_fifo_ctrl.md
# uart_fifo_ctrl

Parametrised TX/RX buffering stage of the UART, between the APB register file and the transmit/receive shift registers. Holds TX characters and RX characters with their per-character line status (parity, framing, break). Provides 16550-style FIFO and non-FIFO modes, programmable RX trigger levels, sticky overrun, an error-in-FIFO flag and a character-timeout indication.

## Interface
Parameters:
- DEPTH, 16: FIFO depth per direction; power of two, ≥4.
- DATA_W, 8: character width.
- TOUT_CHARS, 4: idle character times before `rx_timeout` asserts.
- CW = $clog2(DEPTH+1), derived: count width.

Ports:
- pclk  in  1  clock; all logic on rising edge.
- preset  in  1  reset, asynchronous, active-high.
- fifoen  in  1  1 = FIFO mode (depth DEPTH), 0 = holding-register mode (depth 1).
- txclr  in  1  flush TX side.
- rxclr  in  1  flush RX side.
- rxfiftl  in  2  RX trigger select.
- wdata  in  DATA_W  TX write data.
- thr_wr_en  in  1  TX write strobe.
- tsr_load  in  1  TX pop strobe from the transmitter.
- tx_data  out  DATA_W  TX head entry.
- tx_full, tx_empty  out  1  TX status.
- tx_count  out  CW  TX occupancy.
- rsr_data  in  DATA_W  received character.
- rx_pe, rx_fe, rx_bi  in  1  status of the received character.
- rx_done  in  1  RX push strobe.
- rbr_rd_en  in  1  RX pop strobe (RBR read).
- rbr  out  DATA_W  RX head data.
- rbr_pe, rbr_fe, rbr_bi  out  1  RX head status.
- rx_full, rx_empty  out  1  RX status.
- rx_count  out  CW  RX occupancy.
- rx_trig  out  1  RX trigger level reached.
- rx_err_any  out  1  at least one stored RX entry carries an error.
- overrun  out  1  sticky overrun.
- lsr_rd  in  1  LSR read; clears `overrun`.
- char_tick  in  1  one pulse per character time from the baud generator.
- rx_timeout  out  1  character timeout.

## Operation
- Effective depth is DEPTH when fifoen=1 and 1 when fifoen=0.
- A change of `fifoen`, detected against a registered copy, flushes both sides for one cycle, as `txclr`/`rxclr` do.
- Clear has priority over a same-cycle push or pop. A flush resets the pointers, the counts, the error counter and the timeout counter. It does not clear `overrun`.
- Push when full:
  - TX: data is dropped; no state change.
  - RX: data is dropped; `overrun` is set.
- Pop when empty is ignored. `rbr`/`tx_data` show the stale memory location.
- Simultaneous push and pop:
  - Full: both are performed; count unchanged; RX does not set overrun.
  - Empty: push only.
- RX entry layout is {bi, fe, pe, data}. The error counter increments on a push with any error bit set and decrements on a pop of a head entry with any error bit set; both in the same cycle leave it unchanged. `rx_err_any` = counter≠0.
- Trigger levels (rxfiftl): 00→1, 01→DEPTH/4, 10→DEPTH/2, 11→DEPTH-2. In FIFO mode, `rx_trig` = rx_count ≥ level. In non-FIFO mode, `rx_trig` = !rx_empty.
- Timeout counter:
  - Increments on `char_tick` while fifoen=1 and the RX FIFO is non-empty; saturates at TOUT_CHARS.
  - Zeroed on rx_done, rbr_rd_en, rxclr or RX empty.
  - `rx_timeout` = counter==TOUT_CHARS; it is always 0 when fifoen=0.
- `overrun` clears on `lsr_rd`. A set in the same cycle wins.

## Timing
- Both sides are first-word-fall-through. The head entry is valid whenever !empty.
- A push is visible on the head/empty/count outputs on the next cycle. A pop advances the head on the next cycle.
- All status outputs are registered, except `rx_trig`, which is combinational from rx_count and rxfiftl.
- Reset values:
  - All counts 0.
  - tx_empty=rx_empty=1; tx_full=rx_full=0.
  - overrun=0, rx_err_any=0, rx_timeout=0.
  - rbr/tx_data=0, with memory reset to 0.
- Reset mid-operation discards all contents immediately (asynchronous assertion).
- Pointers wrap modulo DEPTH; full is detected with count==effective depth.

## Structure
- Package `uart_fifo_pkg`:
  - `rx_entry_t` packed struct {bi, fe, pe, data[DATA_W]}.
  - `rxfiftl_e` enum.
  - Function `trig_level(rxfiftl, DEPTH)`.
- Sub-module `uart_sync_fifo` (params WIDTH, DEPTH): FWFT, clear, `depth1` mode input, count/full/empty outputs. It is instantiated twice, with TX width DATA_W and RX width DATA_W+3.
- Overrun, error counter, timeout and trigger logic live in the top level.

## Test plan
- FIFO mode, DEPTH=16: push 0x00..0x0F on TX, then push 0xAA → tx_full=1, 0xAA dropped; 16 pops return 0x00..0x0F in order; tx_empty=1 after the last pop.
- RX fill of 16, then a 17th rx_done → overrun=1. Pop and push in the same cycle while full → count stays 16, no new overrun. lsr_rd → overrun=0.
- Trigger: rxfiftl=01, push 3 → rx_trig=0; 4th push → rx_trig=1. rxfiftl=11 needs 14 entries. With fifoen=0, one push → rx_trig=1.
- Errors: push a clean entry, then an entry with pe=1 → rx_err_any=1. Pop the clean entry → still 1. Pop the pe entry → 0; the head rbr_pe read 1 just before that pop.
- Timeout: 2 entries, 4 char_tick pulses with no activity → rx_timeout=1. rbr_rd_en → 0 next cycle. A rx_done between ticks restarts the count.
- Mode switch and clear: toggle fifoen with both sides non-empty → both empty next cycle. txclr concurrent with thr_wr_en → TX empty. Assert preset mid-transfer → all outputs at their reset values.
